timekeeper_ctrl: RTL

//   Sequencer for the BCD seconds/minutes/hours counter chain built from the mod-60/mod-24 counters.

---
 rtl/timekeeper_ctrl_if.sv | 26 ++
 rtl/timekeeper_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/timekeeper_ctrl_if.sv
// Button, terminal-count and enable/clear signals between the board, the
// timekeeper sequencer and the BCD counter chain.
interface timekeeper_ctrl_if;
  logic       btn_start;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_clr;
  logic       sec_tc;
  logic       min_tc;
  logic       sec_en;
  logic       min_en;
  logic       hr_en;
  logic       clr;
  logic [1:0] mode;
  logic       blink;

  modport master (
    output btn_start, btn_mode, btn_inc, btn_clr, sec_tc, min_tc,
    input  sec_en, min_en, hr_en, clr, mode, blink
  );

  modport slave (
    input  btn_start, btn_mode, btn_inc, btn_clr, sec_tc, min_tc,
    output sec_en, min_en, hr_en, clr, mode, blink
  );
endinterface

// File: rtl/timekeeper_ctrl.sv
// Timekeeper sequencer: 1 Hz prescaler, IDLE/RUN/SET_MIN/SET_HR mode FSM and
// enable/clear generation for the BCD counter chain. TIMEKEEPER_DEBOUNCE_EN adds button debounce.
module timekeeper_ctrl #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input logic              clk,
  input logic              rst,
  timekeeper_ctrl_if.slave bus
);

  localparam int PW      = $clog2(TICK_DIV);
  localparam int NB      = 4;
  localparam int B_START = 0;
  localparam int B_MODE  = 1;
  localparam int B_CLR   = 2;
  localparam int B_INC   = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_SET_MIN = 2'b10,
    S_SET_HR  = 2'b11
  } state_e;

  logic [NB-1:0] btn_raw;
  logic [NB-1:0] sync1_q;
  logic [NB-1:0] sync2_q;
  logic [NB-1:0] level;
  logic [NB-1:0] prev_q;
  logic [NB-1:0] press;

  assign btn_raw = {bus.btn_inc, bus.btn_clr, bus.btn_mode, bus.btn_start};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= level;
    end
  end

`ifdef TIMEKEEPER_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_db
      logic [DW-1:0] cnt_q;
      logic          stable_q;

      // A new level is accepted only after DEBOUNCE_CYC consecutive differing samples.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q    <= '0;
          stable_q <= 1'b0;
        end else if (sync2_q[gi] == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
          stable_q <= sync2_q[gi];
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + DW'(1);
        end
      end

      assign level[gi] = stable_q;
    end
  endgenerate
`else
  logic unused_cfg;

  assign level      = sync2_q;
  assign unused_cfg = (DEBOUNCE_CYC > 0);
`endif

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_edge
      assign press[gi] = level[gi] & ~prev_q[gi];
    end
  endgenerate

  // Only the highest-priority press of a cycle survives.
  logic p_mode, p_start, p_clr, p_inc;

  assign p_mode  = press[B_MODE];
  assign p_start = press[B_START] & ~press[B_MODE];
  assign p_clr   = press[B_CLR] & ~press[B_MODE] & ~press[B_START];
  assign p_inc   = press[B_INC] & ~press[B_MODE] & ~press[B_START] & ~press[B_CLR];

  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (p_mode)       state_d = S_SET_MIN;
        else if (p_start) state_d = S_RUN;
      end
      S_RUN: begin
        if (p_mode)       state_d = S_SET_MIN;
        else if (p_start) state_d = S_IDLE;
      end
      S_SET_MIN: begin
        if (p_mode) state_d = S_SET_HR;
      end
      S_SET_HR: begin
        if (p_mode) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [PW-1:0] presc_q;
  logic          wrap;
  logic          run_tick_q;
  logic          min_inc_q;
  logic          hr_inc_q;
  logic          clr_q;
  logic          blink_q;

  assign wrap = (presc_q == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      run_tick_q <= 1'b0;
      min_inc_q  <= 1'b0;
      hr_inc_q   <= 1'b0;
      clr_q      <= 1'b0;
      blink_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_tick_q <= 1'b0;
      min_inc_q  <= 1'b0;
      hr_inc_q   <= 1'b0;
      clr_q      <= 1'b0;

      // Restarting the prescaler on every transition gives a full period before the first tick.
      if (state_d != state_q) begin
        presc_q <= '0;
        if (state_d == S_IDLE || state_d == S_RUN) blink_q <= 1'b0;
      end else if (state_q != S_IDLE) begin
        if (wrap) begin
          presc_q <= '0;
          if (state_q == S_RUN) run_tick_q <= 1'b1;
          else                  blink_q    <= ~blink_q;
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end else begin
        presc_q <= '0;
      end

      if (state_q == S_IDLE && p_clr)    clr_q     <= 1'b1;
      if (state_q == S_SET_MIN && p_inc) min_inc_q <= 1'b1;
      if (state_q == S_SET_HR && p_inc)  hr_inc_q  <= 1'b1;
    end
  end

  // Carry into minutes/hours only ripples from a seconds tick, never from a set-mode increment.
  assign bus.sec_en = run_tick_q;
  assign bus.min_en = (run_tick_q & bus.sec_tc) | min_inc_q;
  assign bus.hr_en  = (run_tick_q & bus.sec_tc & bus.min_tc) | hr_inc_q;
  assign bus.clr    = clr_q;
  assign bus.mode   = state_q;
  assign bus.blink  = blink_q;

endmodule
